// File: rtl/flow_ctrl_fsm_pkg.sv
// Shared definitions for the flow-control FSM and the FIFO occupancy
// controller it programs: state encodings and default geometry.
package flow_ctrl_fsm_pkg;

  // Default FIFO geometry, shared with the FIFO occupancy/flag controller.
  localparam int DEPTH_DEF    = 8;
  localparam int UMBRAL_W_DEF = 3;
  localparam int CNT_W_DEF    = 16;
  localparam int STATE_W      = 3;

  // State encodings are visible on the state output, so they are fixed.
  // Encodings 5..7 are illegal and recover into ST_ERROR.
  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // States in which the FIFO may be pushed.
  function automatic logic is_run_state(state_t s);
    return (s == ST_IDLE) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/flow_ctrl_cfg_check.sv
// Combinational validity check for a pair of FIFO thresholds.
// A configuration is legal when the almost-empty threshold is strictly
// below the almost-full threshold and the almost-full threshold is
// strictly below the FIFO depth. Any stage that programs thresholds can
// reuse this block so every stage agrees on what "legal" means.
module flow_ctrl_cfg_check
  import flow_ctrl_fsm_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int UMBRAL_W = UMBRAL_W_DEF
) (
  input  logic [UMBRAL_W-1:0] umbral_full,
  input  logic [UMBRAL_W-1:0] umbral_empty,
  output logic                cfg_ok
);

  // Widened copy of the full threshold so it can be compared with DEPTH
  // even when DEPTH itself does not fit in UMBRAL_W bits.
  logic [31:0] full_ext;
  logic [31:0] depth_ext;

  assign full_ext  = 32'(umbral_full);
  assign depth_ext = 32'($unsigned(DEPTH));

  // Both orderings must hold strictly; equal thresholds are rejected.
  always_comb begin
    cfg_ok = 1'b0;
    if ((umbral_empty < umbral_full) && (full_ext < depth_ext)) begin
      cfg_ok = 1'b1;
    end
  end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control state machine wrapped around the FIFO occupancy/flag
// controller. It programs the almost-full/almost-empty thresholds, gates
// upstream pushes into the FIFO, pops words toward the downstream stage,
// counts words drained and parks in a sticky ERROR state on overflow or
// on an illegal threshold configuration.
//
// Handshake semantics:
//   wr_req  is an upstream request; a word is accepted only in a cycle
//           where fifo_wr=1 (wr_req & !fifo_full in IDLE/ACTIVE). A
//           request with fifo_full=1 in IDLE/ACTIVE is an overflow.
//   fifo_rd pops one word in every cycle it is high at a rising edge;
//           it is never raised on an empty FIFO or while down_pause=1,
//           and the popped data is valid from the FIFO one cycle later.
//   up_pause is advisory backpressure to upstream; it does not gate
//           fifo_wr by itself.
// While reset=0 the pulse outputs (fifo_wr, fifo_rd) and the status
// flags (idle_out, error_out) are forced low, so any in-flight request
// is dropped on a reset edge.
module flow_ctrl_fsm
  import flow_ctrl_fsm_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int UMBRAL_W = UMBRAL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_full_in,
  input  logic [UMBRAL_W-1:0] umbral_empty_in,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  input  logic                fifo_almost_full,
  input  logic                wr_req,
  input  logic                down_pause,
  output logic [UMBRAL_W-1:0] full_umbral,
  output logic [UMBRAL_W-1:0] empty_umbral,
  output logic                fifo_wr,
  output logic                fifo_rd,
  output logic [2:0]          state,
  output logic                idle_out,
  output logic                error_out,
  output logic [CNT_W-1:0]    rd_count,
  output logic                up_pause
);

  state_t                state_q;
  logic                  idle_q;
  logic                  error_q;
  logic [UMBRAL_W-1:0]   full_umbral_q;
  logic [UMBRAL_W-1:0]   empty_umbral_q;
  logic [CNT_W-1:0]      rd_count_q;
  logic                  cfg_ok;
  logic                  overflow;
  logic                  fifo_wr_w;
  logic                  fifo_rd_w;

  // Validity of the thresholds currently presented for programming.
  flow_ctrl_cfg_check #(
    .DEPTH    (DEPTH),
    .UMBRAL_W (UMBRAL_W)
  ) u_cfg_check (
    .umbral_full  (umbral_full_in),
    .umbral_empty (umbral_empty_in),
    .cfg_ok       (cfg_ok)
  );

  // A push request against a full FIFO loses data.
  assign overflow = wr_req & fifo_full;

  // Push/pop strobes are decoded from the current state with zero latency
  // toward the FIFO; reset low masks them immediately.
  always_comb begin
    fifo_wr_w = 1'b0;
    fifo_rd_w = 1'b0;
    if (reset) begin
      fifo_wr_w = wr_req & ~fifo_full & is_run_state(state_q);
      fifo_rd_w = (state_q == ST_ACTIVE) & ~fifo_empty & ~down_pause;
    end
  end

  // Main FSM: state plus the registered IDLE/ERROR status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
      idle_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q <= ST_INIT;
          idle_q  <= 1'b0;
          error_q <= 1'b0;
        end
        ST_INIT: begin
          if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (cfg_ok) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
            error_q <= 1'b0;
          end else begin
            state_q <= ST_ERROR;
            idle_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (overflow) begin
            state_q <= ST_ERROR;
            idle_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (~fifo_empty | wr_req) begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
            error_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
            error_q <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (overflow) begin
            state_q <= ST_ERROR;
            idle_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (init) begin
            state_q <= ST_INIT;
            idle_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (fifo_empty & ~wr_req) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
            error_q <= 1'b0;
          end else begin
            state_q <= ST_ACTIVE;
            idle_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        ST_ERROR: begin
          // Sticky: only reset leaves ERROR.
          state_q <= ST_ERROR;
          idle_q  <= 1'b0;
          error_q <= 1'b1;
        end
        default: begin
          // Illegal encodings are treated as a fault.
          state_q <= ST_ERROR;
          idle_q  <= 1'b0;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  // Thresholds track the *_in values only while in INIT and hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_umbral_q  <= '0;
      empty_umbral_q <= '0;
    end else if (state_q == ST_INIT) begin
      full_umbral_q  <= umbral_full_in;
      empty_umbral_q <= umbral_empty_in;
    end
  end

  // Drained-word counter: cleared in INIT, counts every pop, wraps freely.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count_q <= '0;
    end else if (state_q == ST_INIT) begin
      rd_count_q <= '0;
    end else if (fifo_rd_w) begin
      rd_count_q <= rd_count_q + 1'b1;
    end
  end

  assign full_umbral  = full_umbral_q;
  assign empty_umbral = empty_umbral_q;
  assign fifo_wr      = fifo_wr_w;
  assign fifo_rd      = fifo_rd_w;
  assign state        = state_q;
  assign idle_out     = reset & idle_q;
  assign error_out    = reset & error_q;
  assign rd_count     = rd_count_q;
  assign up_pause     = fifo_almost_full | fifo_full;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed bench for flow_ctrl_fsm. Inputs change on the falling edge and
// outputs are compared 1 ns later, so each vector describes one cycle:
// the inputs held during it and the outputs expected before the next
// rising edge.
module tb_flow_ctrl_fsm;

  localparam int UW = 3;
  localparam int CW = 16;

  // Clock/reset block
  logic          clk;
  logic          reset;
  logic          init;
  logic [UW-1:0] umbral_full_in;
  logic [UW-1:0] umbral_empty_in;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_almost_full;
  logic          wr_req;
  logic          down_pause;
  logic [UW-1:0] full_umbral;
  logic [UW-1:0] empty_umbral;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [2:0]    state;
  logic          idle_out;
  logic          error_out;
  logic [CW-1:0] rd_count;
  logic          up_pause;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  flow_ctrl_fsm #(.DEPTH(8), .UMBRAL_W(UW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .umbral_full_in   (umbral_full_in),
    .umbral_empty_in  (umbral_empty_in),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .wr_req           (wr_req),
    .down_pause       (down_pause),
    .full_umbral      (full_umbral),
    .empty_umbral     (empty_umbral),
    .fifo_wr          (fifo_wr),
    .fifo_rd          (fifo_rd),
    .state            (state),
    .idle_out         (idle_out),
    .error_out        (error_out),
    .rd_count         (rd_count),
    .up_pause         (up_pause)
  );

  typedef struct {
    logic          rst;
    logic          ini;
    logic [UW-1:0] uf;
    logic [UW-1:0] ue;
    logic          ff;
    logic          fe;
    logic          faf;
    logic          wr;
    logic          dp;
    logic [2:0]    e_st;
    logic          e_fwr;
    logic          e_frd;
    logic [CW-1:0] e_cnt;
    logic [UW-1:0] e_fu;
    logic [UW-1:0] e_eu;
    logic          e_idl;
    logic          e_err;
    logic          e_upp;
  } vec_t;

  vec_t vecs[$];
  int   errors;
  int   checks;

  // Scoreboard compare: one check, one FAIL line on mismatch.
  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Driver task: applies one cycle worth of inputs.
  task automatic drive(input logic rst, input logic ini, input logic [UW-1:0] uf,
                       input logic [UW-1:0] ue, input logic ff, input logic fe,
                       input logic faf, input logic wr, input logic dp);
    reset            = rst;
    init             = ini;
    umbral_full_in   = uf;
    umbral_empty_in  = ue;
    fifo_full        = ff;
    fifo_empty       = fe;
    fifo_almost_full = faf;
    wr_req           = wr;
    down_pause       = dp;
  endtask

  task automatic add(input logic rst, input logic ini, input logic [UW-1:0] uf,
                     input logic [UW-1:0] ue, input logic ff, input logic fe,
                     input logic faf, input logic wr, input logic dp,
                     input logic [2:0] st, input logic fwr, input logic frd,
                     input logic [CW-1:0] cnt, input logic [UW-1:0] fu,
                     input logic [UW-1:0] eu, input logic idl, input logic err,
                     input logic upp);
    vec_t v;
    v.rst = rst; v.ini = ini; v.uf = uf; v.ue = ue; v.ff = ff; v.fe = fe;
    v.faf = faf; v.wr = wr; v.dp = dp;
    v.e_st = st; v.e_fwr = fwr; v.e_frd = frd; v.e_cnt = cnt; v.e_fu = fu;
    v.e_eu = eu; v.e_idl = idl; v.e_err = err; v.e_upp = upp;
    vecs.push_back(v);
  endtask

  // Compare the core outputs of the current cycle.
  task automatic chk_core(input string tag, input int idx, input logic [2:0] st,
                          input logic fwr, input logic frd, input logic [CW-1:0] cnt,
                          input logic idl, input logic err);
    chk({tag, ".state"},     idx, 32'(state),     32'(st));
    chk({tag, ".fifo_wr"},   idx, 32'(fifo_wr),   32'(fwr));
    chk({tag, ".fifo_rd"},   idx, 32'(fifo_rd),   32'(frd));
    chk({tag, ".rd_count"},  idx, 32'(rd_count),  32'(cnt));
    chk({tag, ".idle_out"},  idx, 32'(idle_out),  32'(idl));
    chk({tag, ".error_out"}, idx, 32'(error_out), 32'(err));
  endtask

  // Program thresholds from a fresh reset and check the resulting state.
  task automatic cfg_case(input string tag, input logic [UW-1:0] uf,
                          input logic [UW-1:0] ue, input logic [2:0] exp_st);
    @(negedge clk); drive(0, 0, uf, ue, 0, 1, 0, 0, 0);
    @(negedge clk); drive(1, 1, uf, ue, 0, 1, 0, 0, 0);
    #1 chk({tag, ".state_rst"}, 0, 32'(state), 32'd0);
    @(negedge clk); drive(1, 0, uf, ue, 0, 1, 0, 0, 0);
    #1 chk({tag, ".state_init"}, 1, 32'(state), 32'd1);
    @(negedge clk); drive(1, 0, uf, ue, 0, 1, 0, 0, 0);
    #1;
    chk_core(tag, 2, exp_st, 0, 0, 0, exp_st == 3'd2, exp_st == 3'd4);
    chk({tag, ".full_umbral"},  2, 32'(full_umbral),  32'(uf));
    chk({tag, ".empty_umbral"}, 2, 32'(empty_umbral), 32'(ue));
  endtask

  initial begin
    int depth_i;
    errors  = 0;
    checks  = 0;
    depth_i = 8;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);

    //   rst ini uf ue ff fe faf wr dp | st fwr frd cnt fu eu idl err upp
    add(0, 0, 0, 0, 0, 1, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 6, 2, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 6, 2, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 6, 2, 0, 1, 0, 0, 0,   1, 0, 0, 0, 6, 2, 0, 0, 0);
    add(1, 0, 6, 2, 0, 1, 0, 1, 0,   2, 1, 0, 0, 6, 2, 1, 0, 0);
    add(1, 0, 6, 2, 0, 0, 0, 1, 0,   3, 1, 1, 0, 6, 2, 0, 0, 0);
    add(1, 0, 6, 2, 0, 0, 0, 1, 0,   3, 1, 1, 1, 6, 2, 0, 0, 0);
    add(1, 0, 6, 2, 0, 0, 0, 0, 0,   3, 0, 1, 2, 6, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, 6, 2, 0, 0, 0, 0, 1, 3, 0, 0, 3, 6, 2, 0, 0, 0);
    add(1, 0, 6, 2, 0, 0, 0, 0, 0,   3, 0, 1, 3, 6, 2, 0, 0, 0);
    add(1, 0, 6, 2, 1, 0, 0, 1, 0,   3, 0, 1, 4, 6, 2, 0, 0, 1);
    add(1, 0, 6, 2, 0, 0, 0, 1, 0,   4, 0, 0, 5, 6, 2, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 1, 0,   4, 0, 0, 5, 6, 2, 0, 1, 0);
    add(0, 0, 6, 2, 0, 0, 0, 1, 0,   4, 0, 0, 5, 6, 2, 0, 0, 0);
    add(1, 1, 3, 5, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 3, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 3, 5, 0, 1, 0, 0, 0,   4, 0, 0, 0, 3, 5, 0, 1, 0);

    // Hold reset for two edges before the table starts.
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ini, vecs[i].uf, vecs[i].ue, vecs[i].ff,
            vecs[i].fe, vecs[i].faf, vecs[i].wr, vecs[i].dp);
      #1;
      chk_core("tbl", i, vecs[i].e_st, vecs[i].e_fwr, vecs[i].e_frd,
               vecs[i].e_cnt, vecs[i].e_idl, vecs[i].e_err);
      chk("tbl.full_umbral",  i, 32'(full_umbral),  32'(vecs[i].e_fu));
      chk("tbl.empty_umbral", i, 32'(empty_umbral), 32'(vecs[i].e_eu));
      chk("tbl.up_pause",     i, 32'(up_pause),     32'(vecs[i].e_upp));
    end

    // Threshold legality boundaries. DEPTH (8) wraps to 0 in 3 bits.
    cfg_case("cfg_depth", depth_i[UW-1:0], 3'd1, 3'd4);
    cfg_case("cfg_equal", 3'd7, 3'd7, 3'd4);
    cfg_case("cfg_zero",  3'd0, 3'd0, 3'd4);
    cfg_case("cfg_max",   3'd7, 3'd6, 3'd2);

    // IDLE holds with nothing to do; a non-empty FIFO wakes it to ACTIVE.
    @(negedge clk); drive(1, 0, 7, 6, 0, 1, 0, 0, 0);
    #1 chk_core("seq", 0, 3'd2, 0, 0, 0, 1, 0);
    @(negedge clk); drive(1, 0, 7, 6, 0, 0, 0, 0, 0);
    #1 chk_core("seq", 1, 3'd2, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); drive(1, 0, 7, 6, 0, 0, 0, 0, 0);
      #1 chk_core("seq_rd", k, 3'd3, 0, 1, CW'(k), 0, 0);
    end
    // Empty with no request drops back to IDLE, then wakes again.
    @(negedge clk); drive(1, 0, 7, 6, 0, 1, 0, 0, 0);
    #1 chk_core("seq", 2, 3'd3, 0, 0, 10, 0, 0);
    @(negedge clk); drive(1, 0, 7, 6, 0, 0, 0, 0, 0);
    #1 chk_core("seq", 3, 3'd2, 0, 0, 10, 1, 0);
    // Reset mid-ACTIVE with a request in flight: strobes masked at once.
    @(negedge clk); drive(0, 0, 7, 6, 0, 0, 0, 1, 0);
    #1 chk_core("seq_rst", 0, 3'd3, 0, 0, 10, 0, 0);
    @(negedge clk); drive(1, 0, 7, 6, 0, 0, 0, 1, 0);
    #1 chk_core("seq_rst", 1, 3'd0, 0, 0, 0, 0, 0);
    chk("seq_rst.full_umbral",  1, 32'(full_umbral),  32'd0);
    chk("seq_rst.empty_umbral", 1, 32'(empty_umbral), 32'd0);
    @(negedge clk); drive(1, 1, 7, 6, 0, 0, 0, 1, 0);
    #1 chk_core("seq_rst", 2, 3'd1, 0, 0, 0, 0, 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
